seg_time_display: RTL and testbench

- Downstream consumer of the clock core: takes its six time digits (hours, minutes and seconds, as tens and ones) and drives the board's 8-digit multiplexed seven-segment display in HH-MM-SS form.
- Time-multiplexes one digit at a time and inserts a ghosting guard at each digit change.
- Latches a coherent snapshot of the digits once per frame, so a rollover never tears the display.
- Supports per-field blinking for set modes.

---
 rtl/seg_time_display.sv | 155 +++++++++++++++
 tb/tb_seg_time_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_time_display.sv
// seg_time_display: drives an 8-digit multiplexed seven-segment display
// with HH-MM-SS from the clock core's six time digits. One digit is lit per
// slot, each slot opens with an all-off guard window against ghosting, the
// digits are snapshotted once per frame, and whole fields can blink.
module seg_time_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD_CYCLES  = 200,
  parameter int BLINK_FRAMES  = 62,
  parameter int HOUR_LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] hrs_tens,
  input  logic [5:0] hrs_ones,
  input  logic [5:0] min_tens,
  input  logic [5:0] min_ones,
  input  logic [5:0] sec_tens,
  input  logic [5:0] sec_ones,
  input  logic [2:0] blink_mask,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'h06;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [35:0]   snap_q, snap_d;   // {hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones}
  logic          frame_start_q, frame_start_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          slot_end;
  logic          frame_load;
  logic [5:0]    digit;
  logic          is_dash;
  logic          field_blink;
  logic [6:0]    pattern;

  function automatic logic [6:0] decode7(input logic [5:0] v);
    case (v)
      6'd0:    decode7 = 7'h40;
      6'd1:    decode7 = 7'h79;
      6'd2:    decode7 = 7'h24;
      6'd3:    decode7 = 7'h30;
      6'd4:    decode7 = 7'h19;
      6'd5:    decode7 = 7'h12;
      6'd6:    decode7 = 7'h02;
      6'd7:    decode7 = 7'h78;
      6'd8:    decode7 = 7'h00;
      6'd9:    decode7 = 7'h10;
      default: decode7 = SEG_ERR;
    endcase
  endfunction

  // Slot/frame timing, blink phase and once-per-frame digit snapshot.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    phase_d  = phase_q;
    slot_end   = (cnt_q == CW'(REFRESH_DIV - 1));
    frame_load = (idx_q == 3'd7) && (cnt_q == '0);
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q - 3'd1;
      if (idx_q == 3'd0) begin
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    snap_d = frame_load ? {hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones}
                        : snap_q;
    frame_start_d = frame_load;
  end

  // Pick the digit for the current slot and build the next an/seg values.
  // Decoding from snap_d keeps the frame's first slot coherent with the load.
  always_comb begin
    digit       = 6'd0;
    is_dash     = 1'b0;
    field_blink = 1'b0;
    case (idx_q)
      3'd7: begin digit = snap_d[35:30]; field_blink = blink_mask[2]; end
      3'd6: begin digit = snap_d[29:24]; field_blink = blink_mask[2]; end
      3'd5: is_dash = 1'b1;
      3'd4: begin digit = snap_d[23:18]; field_blink = blink_mask[1]; end
      3'd3: begin digit = snap_d[17:12]; field_blink = blink_mask[1]; end
      3'd2: is_dash = 1'b1;
      3'd1: begin digit = snap_d[11:6];  field_blink = blink_mask[0]; end
      default: begin digit = snap_d[5:0]; field_blink = blink_mask[0]; end
    endcase

    if (is_dash)
      pattern = SEG_DASH;
    else if (phase_q && field_blink)
      pattern = SEG_BLANK;
    else if ((HOUR_LZ_BLANK != 0) && (idx_q == 3'd7) && (digit == 6'd0))
      pattern = SEG_BLANK;
    else
      pattern = decode7(digit);

    if (cnt_q < CW'(GUARD_CYCLES)) begin
      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = pattern;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 3'd7;
      frame_q       <= '0;
      phase_q       <= 1'b0;
      snap_q        <= '0;
      frame_start_q <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      phase_q       <= phase_d;
      snap_q        <= snap_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = 1'b1;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_time_display.sv
// Bench for seg_time_display: frame-level vector table, hand-written corner
// sequences and a randomized run, all checked every cycle against a
// position-in-frame reference model.
module tb_seg_time_display;

  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BF = 2;
  localparam int FR = RD * 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] din [8];
  logic [2:0] blink_mask;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int total = 0;
  int bad   = 0;
  int p     = 0;
  logic [5:0] snap [8];
  logic [6:0] obs  [8];
  logic [6:0] lut  [10];

  typedef struct packed {
    logic [35:0] digits;   // {ht, ho, mt, mo, st, so}
    logic [55:0] segs;     // slot 7 in the top 7 bits down to slot 0
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  seg_time_display #(
    .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF), .HOUR_LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hrs_tens(din[7]), .hrs_ones(din[6]),
    .min_tens(din[4]), .min_ones(din[3]),
    .sec_tens(din[1]), .sec_ones(din[0]),
    .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", nm, act, exp, p);
    end
  endtask

  function automatic logic [6:0] model_seg(input int slot, input logic ph, input logic [2:0] m);
    int field;
    logic [5:0] v;
    if (slot == 5 || slot == 2) return 7'h3F;
    field = (slot >= 6) ? 2 : ((slot >= 3) ? 1 : 0);
    if (ph && m[field]) return 7'h7F;
    v = snap[slot];
    if (slot == 7 && v == 6'd0) return 7'h7F;
    if (v > 6'd9) return 7'h06;
    return lut[v];
  endfunction

  // One clock: predict from the frame position, let the edge happen, compare.
  task automatic cycle();
    int slot, cnt;
    logic ph, ef;
    logic [7:0] ea;
    logic [6:0] es;
    if (p % FR == 0)
      for (int i = 0; i < 8; i++) snap[i] = din[i];
    slot = 7 - (p / RD) % 8;
    cnt  = p % RD;
    ph   = (((p / FR) / BF) % 2) == 1;
    ef   = (p % FR == 0);
    if (cnt < GC) begin
      ea = 8'hFF;
      es = 7'h7F;
    end else begin
      ea = ~(8'd1 << slot);
      es = model_seg(slot, ph, blink_mask);
    end
    @(posedge clk); #1;
    chk("an", {24'd0, an}, {24'd0, ea});
    chk("seg", {25'd0, seg}, {25'd0, es});
    chk("frame_start", {31'd0, frame_start}, {31'd0, ef});
    chk("dp", {31'd0, dp}, 32'd1);
    if (cnt >= GC) obs[slot] = seg;
    p++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_digits(input logic [35:0] v);
    din[7] = v[35:30]; din[6] = v[29:24];
    din[4] = v[23:18]; din[3] = v[17:12];
    din[1] = v[11:6];  din[0] = v[5:0];
  endtask

  task automatic check_in_reset();
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_in_reset();
    @(posedge clk); #1;
    check_in_reset();
    rst_n = 1'b1;
    p = 0;
  endtask

  initial begin
    logic [55:0] e;
    logic [6:0]  bobs [4][8];

    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    for (int i = 0; i < 8; i++) begin din[i] = 6'd0; obs[i] = 7'h00; end
    blink_mask = 3'b000;

    vecs[0] = '{{6'd2, 6'd3, 6'd5, 6'd9, 6'd5, 6'd5},
                {7'h24, 7'h30, 7'h3F, 7'h12, 7'h10, 7'h3F, 7'h12, 7'h12}};
    vecs[1] = '{{6'd0, 6'd9, 6'd0, 6'd0, 6'd1, 6'd8},
                {7'h7F, 7'h10, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h79, 7'h00}};
    vecs[2] = '{{6'd1, 6'd2, 6'd5, 6'd12, 6'd4, 6'd6},
                {7'h79, 7'h24, 7'h3F, 7'h12, 7'h06, 7'h3F, 7'h19, 7'h02}};
    vecs[3] = '{{6'd63, 6'd7, 6'd3, 6'd3, 6'd10, 6'd0},
                {7'h06, 7'h78, 7'h3F, 7'h30, 7'h30, 7'h3F, 7'h06, 7'h40}};

    // Table: one full frame per vector straight out of reset.
    for (int i = 0; i < 4; i++) begin
      set_digits(vecs[i].digits);
      do_reset();
      run(FR);
      e = vecs[i].segs;
      for (int s = 0; s < 8; s++)
        chk($sformatf("vec%0d_slot%0d", i, s), {25'd0, obs[s]}, {25'd0, e[s*7 +: 7]});
    end

    // Snapshot coherence: sec_ones changes while slot 4 is lit.
    set_digits({6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9});
    do_reset();
    run(30);
    din[0] = 6'd0;
    run(FR - 30);
    chk("snap_hold_sec_ones", {25'd0, obs[0]}, 32'h10);
    run(FR);
    chk("snap_next_sec_ones", {25'd0, obs[0]}, 32'h40);

    // Blink on minutes over four frames.
    set_digits({6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6});
    blink_mask = 3'b010;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      run(FR);
      for (int s = 0; s < 8; s++) bobs[f][s] = obs[s];
    end
    chk("blink_f0_min_t", {25'd0, bobs[0][4]}, 32'h30);
    chk("blink_f1_min_o", {25'd0, bobs[1][3]}, 32'h19);
    chk("blink_f2_min_t", {25'd0, bobs[2][4]}, 32'h7F);
    chk("blink_f3_min_o", {25'd0, bobs[3][3]}, 32'h7F);
    chk("blink_f2_hrs_t", {25'd0, bobs[2][7]}, 32'h79);
    chk("blink_f2_dash", {25'd0, bobs[2][5]}, 32'h3F);
    chk("blink_f3_sec_o", {25'd0, bobs[3][0]}, 32'h02);
    blink_mask = 3'b000;

    // Reset asserted mid-slot-4, fresh snapshot after release.
    set_digits({6'd2, 6'd3, 6'd5, 6'd9, 6'd5, 6'd5});
    do_reset();
    run(28);
    chk("pre_rst_an", {24'd0, an}, 32'hEF);
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset();
    set_digits({6'd1, 6'd8, 6'd0, 6'd7, 6'd4, 6'd2});
    @(posedge clk); #1;
    rst_n = 1'b1;
    p = 0;
    cycle();
    chk("fs_after_rst", {31'd0, frame_start}, 32'd1);
    run(FR - 1);
    chk("post_rst_hrs_o", {25'd0, obs[6]}, 32'h00);
    chk("post_rst_min_o", {25'd0, obs[3]}, 32'h78);

    // Random digits, mid-frame changes and random blink masks.
    do_reset();
    for (int c = 0; c < 8 * FR; c++) begin
      if (c % FR == 17) blink_mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        din[$urandom_range(0, 7)] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                                : 6'($urandom_range(0, 9));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
